// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime-selectable frame format, 3-sample majority
// voting per bit, start-glitch rejection and break detection.
module uart_rx_param #(
    parameter int DW_MAX  = 9,
    parameter int PRESC_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               Stop_Two,
    input  logic [3:0]         Data_Len,
    input  logic [PRESC_W-1:0] Prescale,
    output logic [DW_MAX-1:0]  P_DATA,
    output logic               Data_Valid,
    output logic               Par_Err,
    output logic               Stp_Err,
    output logic               Strt_Glitch,
    output logic               Brk_Det,
    output logic               Busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

    localparam logic [3:0] DL_MAX = 4'(DW_MAX);
    localparam logic [3:0] DL_MIN = 4'd5;

    state_t              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic                armed_q, armed_d;
    logic [PRESC_W-1:0]  edge_q, edge_d;
    logic [3:0]          bit_q, bit_d;
    logic                samp_a_q, samp_a_d, samp_b_q, samp_b_d;
    logic                pe_q, pe_d, pt_q, pt_d, two_q, two_d;
    logic [3:0]          dl_q, dl_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [DW_MAX-1:0]   data_q, data_d;
    logic                par_bad_q, par_bad_d, par_zero_q, par_zero_d;
    logic                stp1_bad_q, stp1_bad_d;
    logic [DW_MAX-1:0]   p_data_q, p_data_d;
    logic                dv_q, dv_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                glitch_q, glitch_d, brk_q, brk_d;

    logic                rxs, vote, vote_now, bit_end;
    logic [PRESC_W-1:0]  half;
    logic                fin, fin_s1bad, fin_stpbad;

    assign rxs      = sync_q[1];
    assign half     = presc_q >> 1;
    assign vote_now = (edge_q == half + PRESC_W'(1));
    assign bit_end  = (edge_q == presc_q - PRESC_W'(1));
    assign vote     = (samp_a_q & samp_b_q) | (samp_a_q & rxs) | (samp_b_q & rxs);

    always_comb begin
        sync_d     = {sync_q[0], RX_IN};
        state_d    = state_q;
        armed_d    = armed_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        samp_a_d   = samp_a_q;
        samp_b_d   = samp_b_q;
        pe_d       = pe_q;
        pt_d       = pt_q;
        two_d      = two_q;
        dl_d       = dl_q;
        presc_d    = presc_q;
        data_d     = data_q;
        par_bad_d  = par_bad_q;
        par_zero_d = par_zero_q;
        stp1_bad_d = stp1_bad_q;
        p_data_d   = p_data_q;
        par_err_d  = par_err_q;
        stp_err_d  = stp_err_q;
        dv_d       = 1'b0;
        glitch_d   = 1'b0;
        brk_d      = 1'b0;
        fin        = 1'b0;
        fin_s1bad  = 1'b0;
        fin_stpbad = 1'b0;

        if (state_q inside {START, DATA, PARITY, STOP1, STOP2}) begin
            if (bit_end) begin
                edge_d = '0;
                bit_d  = bit_q + 4'd1;
            end else begin
                edge_d = edge_q + PRESC_W'(1);
            end
            if (edge_q == half - PRESC_W'(1)) samp_a_d = rxs;
            if (edge_q == half)               samp_b_d = rxs;
        end

        case (state_q)
            IDLE: begin
                if (rxs) armed_d = 1'b1;
                if (!rxs && armed_q) begin
                    state_d    = START;
                    edge_d     = '0;
                    bit_d      = '0;
                    data_d     = '0;
                    par_bad_d  = 1'b0;
                    par_zero_d = 1'b0;
                    stp1_bad_d = 1'b0;
                    pe_d       = PAR_EN;
                    pt_d       = PAR_TYP;
                    two_d      = Stop_Two;
                    if (Data_Len < DL_MIN)      dl_d = DL_MIN;
                    else if (Data_Len > DL_MAX) dl_d = DL_MAX;
                    else                        dl_d = Data_Len;
                    presc_d = (Prescale < PRESC_W'(4)) ? PRESC_W'(4) : Prescale;
                end
            end
            START: begin
                if (vote_now && vote) begin
                    state_d  = IDLE;
                    glitch_d = 1'b1;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // bit_q counts the start bit as 0, so data bit n sits at bit_q = n+1
                if (vote_now) begin
                    for (int i = 0; i < DW_MAX; i++)
                        if (4'(i) == bit_q - 4'd1) data_d[i] = vote;
                end
                if (bit_end && bit_q == dl_q) state_d = pe_q ? PARITY : STOP1;
            end
            PARITY: begin
                if (vote_now) begin
                    par_bad_d  = ((^data_q) ^ pt_q) != vote;
                    par_zero_d = !vote;
                end
                if (bit_end) state_d = STOP1;
            end
            STOP1: begin
                if (vote_now) begin
                    stp1_bad_d = !vote;
                    if (!two_q) begin
                        fin        = 1'b1;
                        fin_s1bad  = !vote;
                        fin_stpbad = !vote;
                    end
                end
                if (two_q && bit_end) state_d = STOP2;
            end
            STOP2: begin
                if (vote_now) begin
                    fin        = 1'b1;
                    fin_s1bad  = stp1_bad_q;
                    fin_stpbad = stp1_bad_q | !vote;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Frame results are registered on the way into DONE so they are visible during it
        if (fin) begin
            state_d   = DONE;
            armed_d   = 1'b0;
            par_err_d = par_bad_q;
            stp_err_d = fin_stpbad;
            brk_d     = (data_q == '0) && (!pe_q || par_zero_q) && fin_s1bad;
            if (!par_bad_q && !fin_stpbad) begin
                dv_d     = 1'b1;
                p_data_d = data_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            sync_q     <= 2'b11;
            armed_q    <= 1'b0;
            edge_q     <= '0;
            bit_q      <= '0;
            samp_a_q   <= 1'b0;
            samp_b_q   <= 1'b0;
            pe_q       <= 1'b0;
            pt_q       <= 1'b0;
            two_q      <= 1'b0;
            dl_q       <= DL_MIN;
            presc_q    <= PRESC_W'(4);
            data_q     <= '0;
            par_bad_q  <= 1'b0;
            par_zero_q <= 1'b0;
            stp1_bad_q <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            glitch_q   <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            armed_q    <= armed_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            samp_a_q   <= samp_a_d;
            samp_b_q   <= samp_b_d;
            pe_q       <= pe_d;
            pt_q       <= pt_d;
            two_q      <= two_d;
            dl_q       <= dl_d;
            presc_q    <= presc_d;
            data_q     <= data_d;
            par_bad_q  <= par_bad_d;
            par_zero_q <= par_zero_d;
            stp1_bad_q <= stp1_bad_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
            glitch_q   <= glitch_d;
            brk_q      <= brk_d;
        end
    end

    assign P_DATA      = p_data_q;
    assign Data_Valid  = dv_q;
    assign Par_Err     = par_err_q;
    assign Stp_Err     = stp_err_q;
    assign Strt_Glitch = glitch_q;
    assign Brk_Det     = brk_q;
    assign Busy        = (state_q != IDLE);

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DW_MAX, default 9, meaning maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PRESC_W, default 8, meaning Prescale width.
REQ-003 SHALL have port CLK  input  1  oversampling clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_IN  input  1  serial line, asynchronous to CLK, idle high.
REQ-006 SHALL have port PAR_EN  input  1  parity bit present.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 SHALL have port Stop_Two  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 SHALL have port Data_Len  input  4  data bits per frame.
REQ-010 SHALL have port Prescale  input  PRESC_W  CLK cycles per bit.
REQ-011 SHALL have port P_DATA  output  DW_MAX  last valid received word, LSB-aligned.
REQ-012 SHALL have port Data_Valid  output  1  one-cycle pulse, P_DATA updated.
REQ-013 SHALL have port Par_Err  output  1  parity error of last completed frame.
REQ-014 SHALL have port Stp_Err  output  1  framing error of last completed frame.
REQ-015 SHALL have port Strt_Glitch  output  1  one-cycle pulse, start bit rejected.
REQ-016 SHALL have port Brk_Det  output  1  one-cycle pulse, break frame detected.
REQ-017 SHALL have port Busy  output  1  high in every state except IDLE.

Function
REQ-018 RX_IN SHALL pass a 2-flop synchronizer; all logic uses the synchronized value (rxs).
REQ-019 PAR_EN, PAR_TYP, Stop_Two, Data_Len and Prescale SHALL be latched on start detection; changes mid-frame have no effect.
REQ-020 Latched Data_Len SHALL be clamped to 5..DW_MAX; latched Prescale < 4 SHALL be treated as 4.
REQ-021 Edge counter SHALL count 0..Prescale-1 per bit, wrapping to 0 and incrementing the bit counter; both clear on entry to START.
REQ-022 Bit value SHALL be the 2-of-3 majority of rxs at edge counts C-1, C, C+1, where C = Prescale>>1.
REQ-023 States SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
REQ-024 IDLE -> START SHALL occur when rxs = 0 and the line is armed. Armed is set by any rxs = 1 sample in IDLE. Armed is cleared on entry to DONE.
REQ-025 START: after the vote completes (edge count C+1), majority 1 -> IDLE with Strt_Glitch pulsed for 1 cycle; majority 0 -> continue to DATA at bit boundary.
REQ-026 DATA SHALL shift in Data_Len bits LSB first. Bits above Data_Len in the assembled word are 0. At the last bit boundary: PAR_EN -> PARITY, else -> STOP1.
REQ-027 Parity check: the computed value is the XOR of the data bits XOR PAR_TYP, and the error is its mismatch with the received parity bit, evaluated in PARITY after the vote.
REQ-028 STOP1: after the vote -> STOP2 at bit boundary if Stop_Two, else -> DONE immediately (no wait for bit end).
REQ-029 STOP2: after the vote -> DONE immediately.
REQ-030 Stp_Err SHALL be set when any stop-bit majority is 0.
REQ-031 DONE SHALL last exactly 1 cycle, then -> IDLE.
REQ-032 In DONE, Par_Err and Stp_Err SHALL be registered for the frame and held until the next DONE.
REQ-033 In DONE, Data_Valid = 1 and P_DATA loaded only if both are 0; otherwise P_DATA is unchanged.
REQ-034 Brk_Det SHALL pulse in DONE when all data bits, parity bit (if any) and first stop bit are 0; Stp_Err is also set.
REQ-035 Start-to-Data_Valid latency SHALL be (1+Data_Len+PAR_EN+Stop_Two)*Prescale + C + 3 cycles from first rxs = 0 (measured at synchronizer output).
REQ-036 Back-to-back frames SHALL be accepted with no idle gap beyond the stop bit(s).

Reset
REQ-037 RST low SHALL immediately force IDLE, armed = 0, and all counters to 0.
REQ-038 RST low SHALL drive P_DATA = 0 and Data_Valid, Par_Err, Stp_Err, Strt_Glitch, Brk_Det, Busy = 0, including when asserted mid-frame.
REQ-039 The synchronizer SHALL reset to 1.
REQ-040 After release, the block SHALL require rxs = 1 before accepting a start.

Verification
REQ-041 Prescale = 8, 8N1, send 0xA5 -> Data_Valid one pulse, P_DATA = 0x0A5, Par_Err = 0, Stp_Err = 0.
REQ-042 Prescale = 16, Data_Len = 7, PAR_EN = 1, PAR_TYP = 1, Stop_Two = 1, send 0x55 with wrong parity -> Par_Err = 1, no Data_Valid, P_DATA unchanged.
REQ-043 RX_IN low for 3 CLK, Prescale = 16 -> Strt_Glitch pulse, return to IDLE, no Data_Valid.
REQ-044 RX_IN held low 20 bit times -> single Brk_Det and Stp_Err = 1; no second frame until RX_IN returns high.
REQ-045 Single-cycle spike at the data-bit center of 0x00 -> P_DATA = 0x000 (majority rejects); two frames 0x3C, 0xC3 back-to-back -> two Data_Valid pulses.
REQ-046 RST asserted mid-DATA, released, then 0x81 sent -> outputs 0 during reset; P_DATA = 0x081 after the frame.
